ask_frame_ctrl: RTL
===================

# ask_frame_ctrl

Frame-level sequencer for the ASK receive chain. It sits behind the preamble and syncword correlators and runs from the same sample clock. It derives the symbol-centre strobe from the preamble hit and enables the syncword correlator only while a sync is expected. After syncword lock it shifts in a length byte and then that many payload bytes, and delivers them over a valid/ready byte interface with error and timeout reporting.

## Interface
- SPS, 4: samples per symbol; even, ≥2 (equals 2×symbol-clock prescaler)
- SYNC_TIMEOUT, 64: symbols allowed between preamble hit and syncword hit
- MAX_LEN, 32: largest legal payload length in bytes (1..255)

Ports:
- sampleclk  in  1  sample clock
- reset  in  1  asynchronous, active-high
- serdata  in  1  sliced ASK sample
- preamble_hit  in  1  preamble correlator decision, level
- syncword_hit  in  1  syncword correlator decision, level
- abort  in  1  synchronous return to HUNT
- corr_en  out  1  enable for syncword correlator clocking
- symb_stb  out  1  one-cycle symbol-centre strobe
- byte_data  out  8  received byte
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  consumer accepts byte
- frame_start  out  1  pulse: syncword locked
- frame_end  out  1  pulse: last payload byte captured
- frame_err  out  1  pulse: bad length or overflow
- sync_timeout  out  1  pulse: syncword not found in time
- busy  out  1  state ≠ HUNT

## Operation
- States: HUNT, SYNC, LEN, PAYLOAD.
- HUNT: the rising edge of preamble_hit (0→1 on consecutive samples) clears the phase counter and the symbol counter, then enters SYNC.
- Phase counter: counts 0..SPS-1 and wraps. symb_stb=1 when phase==SPS/2 in SYNC, LEN and PAYLOAD.
- SYNC:
  - corr_en=symb_stb. The symbol counter increments on each symb_stb.
  - syncword_hit=1 → LEN, bit counter cleared, frame_start pulse.
  - Symbol counter reaching SYNC_TIMEOUT before that → HUNT, sync_timeout pulse.
- LEN: on each symb_stb, shift serdata into an 8-bit register, MSB first. After 8 bits:
  - len==0 or len>MAX_LEN → frame_err, HUNT.
  - otherwise latch byte_cnt=len and go to PAYLOAD.
- PAYLOAD: shift bits the same way.
  - Each completed byte loads byte_data, sets byte_valid and decrements byte_cnt.
  - When byte_cnt reaches 0: frame_end pulses in the same cycle the last byte is loaded, then HUNT.
- Handshake:
  - byte_valid clears on byte_valid&byte_ready.
  - byte_data is stable while byte_valid=1 and byte_ready=0.
  - Completing a byte while byte_valid=1 and byte_ready=0 is an overflow: the new byte is dropped, the pending byte is kept, frame_err pulses, state → HUNT.
  - Completing a byte in the same cycle byte_ready accepts the old one is legal; the new byte is loaded.
- preamble_hit outside HUNT is ignored. syncword_hit outside SYNC is ignored.
- abort=1: next state HUNT, byte_valid cleared, no error pulse. abort has priority over every other transition.
- busy=0 only in HUNT.

## Timing
- Reset values: all outputs 0, byte_data=8'h00, state HUNT, all counters 0.
- Reset is asynchronous and can occur mid-frame: it discards any pending byte immediately.
- Preamble edge sampled at cycle t → phase=0 at t+1 → first symb_stb at t+1+SPS/2.
- Bit capture uses the serdata value in the symb_stb cycle.
- Bytes are registered: byte_valid rises the cycle after the 8th-bit symb_stb. frame_end and frame_err are aligned with that same cycle.
- All pulses are exactly one cycle wide.
- Symbol counter is $clog2(SYNC_TIMEOUT+1) bits wide and saturates. byte_cnt is 8 bits wide.
- Simultaneous syncword_hit and timeout on the same symb_stb: the hit wins.

## Structure
- Package ask_rcv_pkg holds:
  - the state enum (HUNT=0, SYNC=1, LEN=2, PAYLOAD=3);
  - the byte width constant (8);
  - the default SPS, SYNC_TIMEOUT and MAX_LEN values.
- Sub-module ask_symbol_timer implements the phase counter and the symb_stb generator, with a clear input and an enable input.
- The FSM, shifter, counters and output register live in ask_frame_ctrl.

## Test plan
- Ideal frame at SPS=4: preamble edge, syncword, len=3, payload A5 3C FF, byte_ready tied 1 → bytes A5, 3C, FF in order; frame_start once; frame_end with FF; busy then returns to 0.
- Preamble edge with no syncword for 64 symbols → sync_timeout pulse at symbol 64; corr_en toggled exactly 64 times; back in HUNT.
- Length byte 00, then a separate frame with length byte 21h (MAX_LEN=32) → frame_err for each; byte_valid never asserts.
- len=2, byte_ready held 0 → first byte held stable; second byte completes → frame_err, byte_data still holds the first byte.
- abort asserted mid-PAYLOAD and reset asserted mid-LEN → HUNT next cycle or immediately respectively; all outputs at reset values; a following clean frame is received correctly.

Source files
------------

// File: rtl/ask_rcv_pkg.sv
// Shared types and defaults for the ASK receive chain.
package ask_rcv_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SYNC    = 2'd1,
        LEN     = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned DEF_SPS          = 4;
    localparam int unsigned DEF_SYNC_TIMEOUT = 64;
    localparam int unsigned DEF_MAX_LEN      = 32;

endpackage

// File: rtl/ask_symbol_timer.sv
// Sample-phase counter producing a one-cycle strobe at the symbol centre.
module ask_symbol_timer
    import ask_rcv_pkg::*;
#(
    parameter int unsigned SPS = DEF_SPS
) (
    input  logic sampleclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic symb_stb
);

    localparam int unsigned PW = $clog2(SPS);

    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (enable) begin
            phase_d = (phase_q == PW'(SPS - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge sampleclk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign symb_stb = enable && (phase_q == PW'(SPS / 2));

endmodule

// File: rtl/ask_frame_ctrl.sv
// Frame sequencer: preamble edge -> syncword wait -> length byte -> payload bytes,
// delivered over a valid/ready byte port with error and timeout pulses.
module ask_frame_ctrl
    import ask_rcv_pkg::*;
#(
    parameter int unsigned SPS          = DEF_SPS,
    parameter int unsigned SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int unsigned MAX_LEN      = DEF_MAX_LEN
) (
    input  logic              sampleclk,
    input  logic              reset,
    input  logic              serdata,
    input  logic              preamble_hit,
    input  logic              syncword_hit,
    input  logic              abort,
    output logic              corr_en,
    output logic              symb_stb,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_err,
    output logic              sync_timeout,
    output logic              busy
);

    localparam int unsigned SCW = $clog2(SYNC_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              pre_q;
    logic [SCW-1:0]    sym_cnt_q, sym_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              end_q, end_d;
    logic              err_q, err_d;
    logic              to_q, to_d;

    logic              pre_edge;
    logic              timer_clear;
    logic              timer_en;
    logic [BYTE_W-1:0] next_byte;
    logic              byte_done;

    assign pre_edge    = preamble_hit & ~pre_q;
    assign timer_clear = (state_q == HUNT) && pre_edge;
    assign timer_en    = (state_q != HUNT);
    assign next_byte   = {shift_q[BYTE_W-2:0], serdata};
    assign byte_done   = symb_stb && (bit_cnt_q == 3'd7);

    ask_symbol_timer #(
        .SPS (SPS)
    ) u_timer (
        .sampleclk (sampleclk),
        .reset     (reset),
        .clear     (timer_clear),
        .enable    (timer_en),
        .symb_stb  (symb_stb)
    );

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        start_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        to_d       = 1'b0;
        corr_en    = 1'b0;

        if (valid_q && byte_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            HUNT: begin
                if (pre_edge) begin
                    sym_cnt_d = '0;
                    state_d   = SYNC;
                end
            end
            SYNC: begin
                corr_en = symb_stb;
                if (symb_stb && (sym_cnt_q != SCW'(SYNC_TIMEOUT))) begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
                // A hit on the timeout strobe still wins.
                if (syncword_hit) begin
                    state_d   = LEN;
                    bit_cnt_d = '0;
                    start_d   = 1'b1;
                end else if (symb_stb && (sym_cnt_q >= SCW'(SYNC_TIMEOUT - 1))) begin
                    state_d = HUNT;
                    to_d    = 1'b1;
                end
            end
            LEN: begin
                if (symb_stb) begin
                    shift_d   = next_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if ((next_byte == '0) || (next_byte > BYTE_W'(MAX_LEN))) begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end else begin
                            byte_cnt_d = next_byte;
                            state_d    = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (symb_stb) begin
                    shift_d   = next_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if (valid_q && !byte_ready) begin
                            // Overflow: keep the pending byte, drop the new one.
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end else begin
                            data_d     = next_byte;
                            valid_d    = 1'b1;
                            byte_cnt_d = byte_cnt_q - 1'b1;
                            if (byte_cnt_q == 8'd1) begin
                                end_d   = 1'b1;
                                state_d = HUNT;
                            end
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (abort) begin
            state_d = HUNT;
            valid_d = 1'b0;
            data_d  = '0;
            start_d = 1'b0;
            end_d   = 1'b0;
            err_d   = 1'b0;
            to_d    = 1'b0;
        end
    end

    always_ff @(posedge sampleclk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            pre_q      <= 1'b0;
            sym_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= preamble_hit;
            sym_cnt_q  <= sym_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
            err_q      <= err_d;
            to_q       <= to_d;
        end
    end

    assign byte_data    = data_q;
    assign byte_valid   = valid_q;
    assign frame_start  = start_q;
    assign frame_end    = end_q;
    assign frame_err    = err_q;
    assign sync_timeout = to_q;
    assign busy         = (state_q != HUNT);

endmodule
